// File: rtl/lcd_roi_tracker_if.sv
// ---------------------------------------------------------------------------
// lcd_roi_tracker_if
//   Bundles the LCD timing inputs and the geometry/ROI outputs of
//   lcd_roi_tracker so the tracker and its environment connect through one
//   port.
//
//   Timing:   VS, HS, DE           (driven by the video source)
//   Geometry: H_CNT, V_CNT, H_SIZE, V_SIZE, LOCKED, FRAME_START
//   Window:   ACTIV_V, ACTIV_C, LINE
//
//   There is no flow control on this bus: the timing inputs are sampled on
//   every rising clock edge and every output is a register that is valid on
//   every cycle (no valid/ready pair).
//
//   Modports:
//     master - video source / consumer side (drives timing, reads results)
//     slave  - tracker side (reads timing, drives results)
// ---------------------------------------------------------------------------
interface lcd_roi_tracker_if #(
    parameter int CW = 16
);
    logic          VS;
    logic          HS;
    logic          DE;
    logic [CW-1:0] H_CNT;
    logic [CW-1:0] V_CNT;
    logic [CW-1:0] H_SIZE;
    logic [CW-1:0] V_SIZE;
    logic          LOCKED;
    logic          FRAME_START;
    logic          ACTIV_V;
    logic          ACTIV_C;
    logic          LINE;

    modport master (
        output VS, HS, DE,
        input  H_CNT, V_CNT, H_SIZE, V_SIZE, LOCKED, FRAME_START,
        input  ACTIV_V, ACTIV_C, LINE
    );

    modport slave (
        input  VS, HS, DE,
        output H_CNT, V_CNT, H_SIZE, V_SIZE, LOCKED, FRAME_START,
        output ACTIV_V, ACTIV_C, LINE
    );
endinterface

// File: rtl/lcd_roi_tracker.sv
// ---------------------------------------------------------------------------
// lcd_roi_tracker
//   Measures the active frame geometry of an LCD timing stream (DE pixels per
//   line, HS rises per frame while VS is high), qualifies it with a lock state
//   machine, and produces a centred ROI window plus its border overlay.
//
//   Ports:
//     CLK  - pixel clock, all logic on the rising edge
//     RST  - synchronous active-high reset
//     bus  - lcd_roi_tracker_if.slave
//              in : VS, HS, DE
//              out: H_CNT, V_CNT        live pixel / line counters
//                   H_SIZE, V_SIZE      geometry captured at lock
//                   LOCKED              lock FSM is in the LOCKED state
//                   FRAME_START         1-cycle pulse after a VS rise
//                   ACTIV_V             registered HS & VS
//                   ACTIV_C, LINE       ROI interior / ROI border
// ---------------------------------------------------------------------------
module lcd_roi_tracker #(
    parameter int CW          = 16,
    parameter int ROI_W       = 224,
    parameter int ROI_H       = 224,
    parameter int BORDER      = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    lcd_roi_tracker_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] ROI_W_C   = CW'(ROI_W);
    localparam logic [CW-1:0] ROI_H_C   = CW'(ROI_H);
    localparam logic [CW-1:0] BORDER_C  = CW'(BORDER);
    localparam logic [3:0]    MATCH_TGT = 4'(LOCK_FRAMES - 1);

    // Edge detection
    logic hs_q;
    logic vs_q;
    logic hs_rise;
    logic vs_rise;

    // Counters and line-length capture
    logic [CW-1:0] h_cnt_q,  h_cnt_d;
    logic [CW-1:0] v_cnt_q,  v_cnt_d;
    logic [CW-1:0] h_line_q, h_line_d;

    // Lock FSM state and geometry
    state_t        state_q;
    logic [3:0]    match_q;
    logic [CW-1:0] prev_h_q;
    logic [CW-1:0] prev_v_q;
    logic [CW-1:0] h_size_q;
    logic [CW-1:0] v_size_q;
    logic [CW-1:0] h_lo_q, h_hi_q, v_lo_q, v_hi_q;
    logic [CW-1:0] h_lo_d, h_hi_d, v_lo_d, v_hi_d;

    // Registered outputs
    logic frame_start_q;
    logic activ_v_q;
    logic activ_c_q;
    logic line_q;

    // Frame sample taken at vs_rise. h_line_q is the value before this edge,
    // so a line ending in the same cycle as vs_rise belongs to the next frame.
    logic [CW-1:0] samp_h;
    logic [CW-1:0] samp_v;
    logic          samp_nz;
    logic          samp_eq;

    logic in_roi;
    logic on_border;

    assign hs_rise = ~hs_q & bus.HS;
    assign vs_rise = ~vs_q & bus.VS;

    assign samp_h  = h_line_q;
    assign samp_v  = v_cnt_q;
    assign samp_nz = (samp_h != '0) || (samp_v != '0);
    assign samp_eq = (samp_h == prev_h_q) && (samp_v == prev_v_q);

    // Pixel / line counters, both saturating. vs_rise has priority over
    // hs_rise for V_CNT; H_CNT only cares about hs_rise.
    always_comb begin
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        h_line_d = h_line_q;

        if (hs_rise) begin
            h_cnt_d = '0;
        end else if (bus.DE && (h_cnt_q != CNT_MAX)) begin
            h_cnt_d = h_cnt_q + CNT_ONE;
        end

        if (vs_rise) begin
            v_cnt_d = '0;
        end else if (hs_rise && bus.VS && (v_cnt_q != CNT_MAX)) begin
            v_cnt_d = v_cnt_q + CNT_ONE;
        end

        // Blanking lines with no DE must not overwrite the measured width.
        if (hs_rise && (h_cnt_q != '0)) begin
            h_line_d = h_cnt_q;
        end
    end

    // Centred bounds for the sampled geometry; an ROI that does not fit is
    // clamped to the full extent.
    always_comb begin
        h_lo_d = '0;
        h_hi_d = samp_h;
        v_lo_d = '0;
        v_hi_d = samp_v;
        if (ROI_W_C < samp_h) begin
            h_lo_d = (samp_h >> 1) - (ROI_W_C >> 1);
            h_hi_d = (samp_h >> 1) + (ROI_W_C >> 1);
        end
        if (ROI_H_C < samp_v) begin
            v_lo_d = (samp_v >> 1) - (ROI_H_C >> 1);
            v_hi_d = (samp_v >> 1) + (ROI_H_C >> 1);
        end
    end

    // Window decode on the current counters; registered below for a fixed
    // one-cycle latency.
    always_comb begin
        in_roi    = (state_q == ST_LOCKED) &&
                    (h_cnt_q >= h_lo_q) && (h_cnt_q < h_hi_q) &&
                    (v_cnt_q >= v_lo_q) && (v_cnt_q < v_hi_q);
        on_border = (h_cnt_q <  h_lo_q + BORDER_C) ||
                    (h_cnt_q >= h_hi_q - BORDER_C) ||
                    (v_cnt_q <  v_lo_q + BORDER_C) ||
                    (v_cnt_q >= v_hi_q - BORDER_C);
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_line_q      <= '0;
            frame_start_q <= 1'b0;
            activ_v_q     <= 1'b0;
            activ_c_q     <= 1'b0;
            line_q        <= 1'b0;
        end else begin
            hs_q          <= bus.HS;
            vs_q          <= bus.VS;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_line_q      <= h_line_d;
            frame_start_q <= vs_rise;
            activ_v_q     <= bus.HS & bus.VS;
            activ_c_q     <= in_roi;
            line_q        <= in_roi & on_border;
        end
    end

    // Lock FSM. Every decision is taken at vs_rise; sizes and bounds are
    // loaded only on entry to / confirmation in LOCKED and otherwise hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_UNLOCKED;
            match_q  <= '0;
            prev_h_q <= '0;
            prev_v_q <= '0;
            h_size_q <= '0;
            v_size_q <= '0;
            h_lo_q   <= '0;
            h_hi_q   <= '0;
            v_lo_q   <= '0;
            v_hi_q   <= '0;
        end else if (vs_rise) begin
            case (state_q)
                ST_UNLOCKED: begin
                    prev_h_q <= samp_h;
                    prev_v_q <= samp_v;
                    match_q  <= '0;
                    if (samp_nz) begin
                        if (LOCK_FRAMES == 1) begin
                            state_q  <= ST_LOCKED;
                            h_size_q <= samp_h;
                            v_size_q <= samp_v;
                            h_lo_q   <= h_lo_d;
                            h_hi_q   <= h_hi_d;
                            v_lo_q   <= v_lo_d;
                            v_hi_q   <= v_hi_d;
                        end else begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (samp_eq) begin
                        match_q <= match_q + 4'd1;
                        if ((match_q + 4'd1) == MATCH_TGT) begin
                            state_q  <= ST_LOCKED;
                            h_size_q <= samp_h;
                            v_size_q <= samp_v;
                            h_lo_q   <= h_lo_d;
                            h_hi_q   <= h_hi_d;
                            v_lo_q   <= v_lo_d;
                            v_hi_q   <= v_hi_d;
                        end
                    end else begin
                        prev_h_q <= samp_h;
                        prev_v_q <= samp_v;
                        match_q  <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (samp_eq) begin
                        h_lo_q <= h_lo_d;
                        h_hi_q <= h_hi_d;
                        v_lo_q <= v_lo_d;
                        v_hi_q <= v_hi_d;
                    end else begin
                        // Sizes hold their last locked values.
                        state_q <= ST_UNLOCKED;
                    end
                end
                default: state_q <= ST_UNLOCKED;
            endcase
        end
    end

    assign bus.H_CNT       = h_cnt_q;
    assign bus.V_CNT       = v_cnt_q;
    assign bus.H_SIZE      = h_size_q;
    assign bus.V_SIZE      = v_size_q;
    assign bus.LOCKED      = (state_q == ST_LOCKED);
    assign bus.FRAME_START = frame_start_q;
    assign bus.ACTIV_V     = activ_v_q;
    assign bus.ACTIV_C     = activ_c_q;
    assign bus.LINE        = line_q;

endmodule

// File: tb/tb_lcd_roi_tracker.sv
// ---------------------------------------------------------------------------
// tb_lcd_roi_tracker
//   Bench for lcd_roi_tracker. A full-size instance (CW=16, 224x224 ROI,
//   LOCK_FRAMES=2) is driven with compressed LCD frames: every line gets an
//   HS pulse but only the last line and a few probe lines carry DE, which is
//   enough to measure width and to exercise the ROI edges. A small instance
//   (CW=4, LOCK_FRAMES=1) covers simultaneous edges and saturation.
// ---------------------------------------------------------------------------
module tb_lcd_roi_tracker;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    lcd_roi_tracker_if #(.CW(16)) bus ();
    lcd_roi_tracker_if #(.CW(4))  sbus ();

    lcd_roi_tracker #(
        .CW(16), .ROI_W(224), .ROI_H(224), .BORDER(1), .LOCK_FRAMES(2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    lcd_roi_tracker #(
        .CW(4), .ROI_W(4), .ROI_H(4), .BORDER(1), .LOCK_FRAMES(1)
    ) dut_s (
        .CLK (CLK),
        .RST (RST),
        .bus (sbus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected {ACTIV_C, LINE} per probed cycle
    logic [1:0] exp_q[$];

    // Expected ROI bounds for the frame currently being sent
    int exp_hlo, exp_hhi, exp_vlo, exp_vhi;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic vs, input logic hs, input logic de);
        bus.VS = vs;
        bus.HS = hs;
        bus.DE = de;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_s(input logic vs, input logic hs, input logic de);
        sbus.VS = vs;
        sbus.HS = hs;
        sbus.DE = de;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [1:0] roi_exp(input int k, input int l, input bit locked);
        logic a;
        logic b;
        a = locked && (k >= exp_hlo) && (k < exp_hhi) && (l >= exp_vlo) && (l < exp_vhi);
        b = a && ((k < exp_hlo + 1) || (k >= exp_hhi - 1) ||
                  (l < exp_vlo + 1) || (l >= exp_vhi - 1));
        return {a, b};
    endfunction

    // Sends one frame: VS rise, h lines (HS pulse each), then VS low and a
    // closing HS pulse so the last line's width is latched. lock_exp is the
    // LOCKED value expected right after this frame's VS rise.
    task automatic send_frame(input int w, input int h, input bit lock_exp,
                              input bit probe, input int abort_line);
        bit is_probe;
        logic [1:0] exp_v;
        drive(1, 0, 0);
        n_checks++;
        if (bus.FRAME_START !== 1'b1) begin
            n_errors++;
            $display("FAIL frame_start_high: got %b want 1", bus.FRAME_START);
        end
        n_checks++;
        if (bus.LOCKED !== lock_exp) begin
            n_errors++;
            $display("FAIL locked_at_vs_rise: got %b want %b", bus.LOCKED, lock_exp);
        end
        n_checks++;
        if (bus.V_CNT !== 16'd0) begin
            n_errors++;
            $display("FAIL v_cnt_clear: got %0d want 0", bus.V_CNT);
        end
        drive(1, 0, 0);
        n_checks++;
        if (bus.FRAME_START !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_start_one_cycle: got %b want 0", bus.FRAME_START);
        end
        for (int l = 1; l <= h; l++) begin
            if (l == abort_line) begin
                RST = 1'b1;
                drive(1, 1, 0);
                n_checks++;
                if ({bus.H_CNT, bus.V_CNT, bus.H_SIZE, bus.V_SIZE, bus.LOCKED,
                     bus.FRAME_START, bus.ACTIV_V, bus.ACTIV_C, bus.LINE} !== '0) begin
                    n_errors++;
                    $display("FAIL mid_reset_outputs: got h=%0d v=%0d hs=%0d vs=%0d lk=%b fs=%b av=%b ac=%b ln=%b want all 0",
                             bus.H_CNT, bus.V_CNT, bus.H_SIZE, bus.V_SIZE, bus.LOCKED,
                             bus.FRAME_START, bus.ACTIV_V, bus.ACTIV_C, bus.LINE);
                end
                RST = 1'b0;
            end
            drive(1, 1, 0);
            if (l == 1) begin
                n_checks++;
                if (bus.ACTIV_V !== 1'b1) begin
                    n_errors++;
                    $display("FAIL activ_v_high: got %b want 1", bus.ACTIV_V);
                end
            end
            drive(1, 0, 0);
            is_probe = probe && (l == 127 || l == 128 || l == 200 || l == 351 || l == 352);
            if (is_probe || l == h) begin
                for (int k = 0; k <= w; k++) begin
                    if (is_probe) exp_q.push_back(roi_exp(k, l, lock_exp));
                    drive(1, 0, (k < w) ? 1'b1 : 1'b0);
                    if (is_probe) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_errors++;
                            $display("FAIL roi_queue_empty at (%0d,%0d)", k, l);
                        end else begin
                            exp_v = exp_q.pop_front();
                            if ({bus.ACTIV_C, bus.LINE} !== exp_v) begin
                                n_errors++;
                                $display("FAIL roi_pixel (%0d,%0d): got activ_c=%b line=%b want activ_c=%b line=%b",
                                         k, l, bus.ACTIV_C, bus.LINE, exp_v[1], exp_v[0]);
                            end
                        end
                    end
                end
            end
        end
        if (abort_line == 0) begin
            n_checks++;
            if (bus.V_CNT !== 16'(h)) begin
                n_errors++;
                $display("FAIL v_cnt_lines: got %0d want %0d", bus.V_CNT, h);
            end
        end
        drive(0, 0, 0);
        n_checks++;
        if (bus.H_CNT !== 16'(w)) begin
            n_errors++;
            $display("FAIL h_cnt_line_end: got %0d want %0d", bus.H_CNT, w);
        end
        drive(0, 1, 0);
        drive(0, 0, 0);
        n_checks++;
        if (bus.H_CNT !== 16'd0) begin
            n_errors++;
            $display("FAIL h_cnt_hs_clear: got %0d want 0", bus.H_CNT);
        end
    endtask

    task automatic check_sizes(input string name, input int hs, input int vs);
        n_checks++;
        if (bus.H_SIZE !== 16'(hs) || bus.V_SIZE !== 16'(vs)) begin
            n_errors++;
            $display("FAIL %s: got %0dx%0d want %0dx%0d", name, bus.H_SIZE, bus.V_SIZE, hs, vs);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) drive(0, 0, 0);
        n_checks++;
        if ({bus.H_CNT, bus.V_CNT, bus.H_SIZE, bus.V_SIZE, bus.LOCKED,
             bus.FRAME_START, bus.ACTIV_V, bus.ACTIV_C, bus.LINE} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got lk=%b hsz=%0d vsz=%0d want all 0",
                     bus.LOCKED, bus.H_SIZE, bus.V_SIZE);
        end
        n_checks++;
        if ({sbus.H_CNT, sbus.V_CNT, sbus.LOCKED, sbus.ACTIV_C} !== '0) begin
            n_errors++;
            $display("FAIL reset_small_outputs: got h=%0d v=%0d lk=%b want 0",
                     sbus.H_CNT, sbus.V_CNT, sbus.LOCKED);
        end
        RST = 1'b0;
        drive(1, 1, 0);
        n_checks++;
        if (bus.ACTIV_V !== 1'b1 || bus.LOCKED !== 1'b0) begin
            n_errors++;
            $display("FAIL activ_v_unlocked: got av=%b lk=%b want av=1 lk=0", bus.ACTIV_V, bus.LOCKED);
        end
        drive(0, 0, 0);
        n_checks++;
        if (bus.ACTIV_V !== 1'b0) begin
            n_errors++;
            $display("FAIL activ_v_low: got %b want 0", bus.ACTIV_V);
        end
    endtask

    task automatic test_lock();
        send_frame(800, 480, 1'b0, 1'b0, 0);
        send_frame(800, 480, 1'b0, 1'b0, 0);
        send_frame(800, 480, 1'b1, 1'b0, 0);
        check_sizes("lock_sizes", 800, 480);
    endtask

    task automatic test_roi();
        exp_hlo = 288; exp_hhi = 512; exp_vlo = 128; exp_vhi = 352;
        send_frame(800, 480, 1'b1, 1'b1, 0);
    endtask

    task automatic test_geometry_change();
        send_frame(640, 480, 1'b1, 1'b0, 0);
        send_frame(640, 480, 1'b0, 1'b1, 0);
        check_sizes("sizes_held_unlocked", 800, 480);
        send_frame(640, 480, 1'b0, 1'b0, 0);
        exp_hlo = 208; exp_hhi = 432; exp_vlo = 128; exp_vhi = 352;
        send_frame(640, 480, 1'b1, 1'b1, 0);
        check_sizes("relock_640", 640, 480);
    endtask

    task automatic test_clamp();
        send_frame(200, 480, 1'b1, 1'b0, 0);
        send_frame(200, 480, 1'b0, 1'b0, 0);
        send_frame(200, 480, 1'b0, 1'b0, 0);
        exp_hlo = 0; exp_hhi = 200; exp_vlo = 128; exp_vhi = 352;
        send_frame(200, 480, 1'b1, 1'b1, 0);
        check_sizes("clamp_sizes", 200, 480);
    endtask

    task automatic test_mid_reset();
        send_frame(800, 480, 1'b1, 1'b0, 200);
        send_frame(800, 480, 1'b0, 1'b0, 0);
        send_frame(800, 480, 1'b0, 1'b0, 0);
        send_frame(800, 480, 1'b1, 1'b0, 0);
        check_sizes("relock_after_reset", 800, 480);
    endtask

    task automatic test_edges_saturation();
        repeat (3) drive_s(0, 0, 1);
        n_checks++;
        if (sbus.H_CNT !== 4'd3) begin
            n_errors++;
            $display("FAIL small_h_cnt: got %0d want 3", sbus.H_CNT);
        end
        drive_s(1, 0, 0);
        drive_s(1, 1, 0);
        drive_s(1, 0, 0);
        drive_s(1, 1, 0);
        drive_s(1, 0, 0);
        drive_s(1, 0, 1);
        drive_s(1, 0, 1);
        n_checks++;
        if (sbus.V_CNT !== 4'd2 || sbus.H_CNT !== 4'd2) begin
            n_errors++;
            $display("FAIL small_counts: got h=%0d v=%0d want h=2 v=2", sbus.H_CNT, sbus.V_CNT);
        end
        drive_s(0, 0, 0);
        drive_s(1, 1, 0);
        n_checks++;
        if (sbus.V_CNT !== 4'd0 || sbus.H_CNT !== 4'd0) begin
            n_errors++;
            $display("FAIL simultaneous_edges: got h=%0d v=%0d want h=0 v=0", sbus.H_CNT, sbus.V_CNT);
        end
        // Sample {3,2} is non-zero and LOCK_FRAMES=1, so lock is immediate.
        n_checks++;
        if (sbus.LOCKED !== 1'b1 || sbus.H_SIZE !== 4'd3 || sbus.V_SIZE !== 4'd2) begin
            n_errors++;
            $display("FAIL lock_frames_1: got lk=%b size=%0dx%0d want lk=1 size=3x2",
                     sbus.LOCKED, sbus.H_SIZE, sbus.V_SIZE);
        end
        drive_s(1, 0, 0);
        repeat (20) drive_s(1, 0, 1);
        n_checks++;
        if (sbus.H_CNT !== 4'd15) begin
            n_errors++;
            $display("FAIL h_cnt_saturate: got %0d want 15", sbus.H_CNT);
        end
        repeat (20) begin
            drive_s(1, 1, 0);
            drive_s(1, 0, 0);
        end
        n_checks++;
        if (sbus.V_CNT !== 4'd15) begin
            n_errors++;
            $display("FAIL v_cnt_saturate: got %0d want 15", sbus.V_CNT);
        end
        drive_s(0, 0, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        RST     = 1'b1;
        bus.VS  = 1'b0;
        bus.HS  = 1'b0;
        bus.DE  = 1'b0;
        sbus.VS = 1'b0;
        sbus.HS = 1'b0;
        sbus.DE = 1'b0;
        test_reset();
        test_lock();
        test_roi();
        test_geometry_change();
        test_clamp();
        test_mid_reset();
        test_edges_saturation();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL roi_queue_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_roi_tracker.md
Name: lcd_roi_tracker

Overview:
- Measures the active frame geometry (DE pixels per line, HS-rise lines per frame) from LCD VS/HS/DE timing.
- Qualifies the geometry with a lock state machine.
- Generates a centred, parametrised region-of-interest (ROI) window and its border overlay for the video capture and overlay path.
- Successor to the fixed-size centre-box counter; adds reset, configurable ROI size and border thickness, clamping, and lock qualification.

Parameters:
- CW, 16, width of all counters and size outputs
- ROI_W, 224, ROI width in pixels
- ROI_H, 224, ROI height in lines
- BORDER, 1, border thickness in pixels/lines; must satisfy 1 <= BORDER <= min(ROI_W, ROI_H)/2
- LOCK_FRAMES, 2, number of consecutive identical frame measurements needed to assert LOCKED (legal range 1 to 15)

Ports:
- CLK  in  1  pixel clock; all logic on rising edge
- RST  in  1  synchronous active-high reset
- VS  in  1  vertical sync, active-high
- HS  in  1  horizontal sync, active-high
- DE  in  1  data enable, high on active pixels
- H_CNT  out  CW  active pixel index in current line
- V_CNT  out  CW  line index in current frame
- H_SIZE  out  CW  locked frame width
- V_SIZE  out  CW  locked frame height
- LOCKED  out  1  geometry stable
- FRAME_START  out  1  one-cycle pulse on VS rise
- ACTIV_V  out  1  registered HS & VS
- ACTIV_C  out  1  current pixel inside ROI
- LINE  out  1  current pixel on ROI border

Behaviour:
- Reset: all outputs, counters, captures and edge registers go to 0; FSM goes to UNLOCKED; match counter goes to 0. A reset mid-frame discards that frame; the first VS rise after reset is treated as the first capture.
- Edge detect: rHS and rVS are registered copies. hs_rise = !rHS & HS; vs_rise = !rVS & VS.
- H_CNT:
  - Cleared to 0 on hs_rise.
  - Otherwise incremented on DE.
  - Saturates at all-ones and never wraps.
- Line length: on hs_rise with H_CNT != 0, h_line <= H_CNT. Zero-length blanking lines are ignored.
- V_CNT:
  - Cleared to 0 on vs_rise.
  - Otherwise incremented on hs_rise while VS = 1.
  - Saturates at all-ones.
  - When vs_rise and hs_rise occur in the same cycle, vs_rise wins and V_CNT = 0. H_CNT also clears.
- Frame capture: on vs_rise, sample = {h_line, V_CNT}. FRAME_START pulses high for exactly 1 cycle, registered one cycle after the vs_rise cycle.
- Lock FSM:
  - UNLOCKED, on vs_rise: store the sample as prev and set match = 0. If the sample is non-zero, go to CHECK.
  - CHECK, on vs_rise: if sample == prev, match++, and at match == LOCK_FRAMES - 1 go to LOCKED, loading H_SIZE/V_SIZE and the bounds. Else store prev = sample, set match = 0, and stay in CHECK.
  - LOCKED, on vs_rise: if sample == prev, reload the bounds (no change). Else go to UNLOCKED immediately, clear LOCKED, and hold H_SIZE/V_SIZE at their last values.
  - With LOCK_FRAMES = 1, a non-zero sample in UNLOCKED goes directly to LOCKED.
  - LOCKED = 1 exactly in the LOCKED state.
- Bounds are registered and change only at vs_rise:
  - h_lo = H_SIZE/2 - ROI_W/2
  - h_hi = H_SIZE/2 + ROI_W/2
  - If ROI_W >= H_SIZE, clamp to h_lo = 0 and h_hi = H_SIZE.
  - The vertical bounds follow the same rules using V_SIZE and ROI_H.
  - All arithmetic is unsigned CW-bit; halving truncates.
- ACTIV_C (registered, 1-cycle latency from the counters): LOCKED & (h_lo <= H_CNT < h_hi) & (v_lo <= V_CNT < v_hi).
- LINE (registered, same latency): the ACTIV_C condition AND at least one of:
  - H_CNT < h_lo + BORDER
  - H_CNT >= h_hi - BORDER
  - V_CNT < v_lo + BORDER
  - V_CNT >= v_hi - BORDER
- LINE implies ACTIV_C. Both are 0 whenever LOCKED = 0.
- ACTIV_V <= HS & VS each cycle, including when unlocked.

Test Plan:
- Reset and lock, 800x480: RST, then 3 frames with 800 DE per line and 480 HS-rises in VS. Required: LOCKED = 0 after frame 1; LOCKED = 1 at the 3rd vs_rise (LOCK_FRAMES = 2); H_SIZE = 800, V_SIZE = 480; bounds h 288..512 and v 128..352.
- ROI and border: locked 800x480 with BORDER = 1. Required: ACTIV_C = 1 at (288,128) and (511,351), 0 at (512,200) and (287,200). LINE = 1 at (288,200), (511,200) and (300,128); LINE = 0 at (300,200). All values appear 1 cycle after the counters.
- Clamp: ROI_W = 224 with 200-pixel lines, lock achieved. Required: h_lo = 0, h_hi = 200; ACTIV_C is high across the whole line inside the vertical band.
- Geometry change: while locked, one frame of 640 pixels per line. Required: LOCKED drops at that vs_rise and ACTIV_C/LINE go to 0. After 2 more 640-pixel frames, relock with H_SIZE = 640 and h_lo = 208.
- Simultaneous edges and saturation: vs_rise and hs_rise in the same cycle gives V_CNT = 0 and H_CNT = 0. With CW = 4, 20 DE cycles hold H_CNT at 15.
- Mid-frame reset: assert RST at line 200 of a locked frame. Required: all outputs are 0 the next cycle; relock takes 2 full frames after the first post-reset vs_rise.
